// File: rtl/mux_n_rr.sv
// ============================================================================
//  Module   : mux_n_rr
//  Brief    : N-channel registered mux with valid/ready handshakes and
//             fixed or round-robin channel selection.
//             Optional macro MUX_N_RR_STATS_EN adds the xfer_cnt port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mux_n_rr #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef MUX_N_RR_STATS_EN
    ,
    output logic [15:0]          xfer_cnt
`endif
);

    localparam logic [SELW-1:0] c_LAST_CH = SELW'(NCH - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [WIDTH-1:0]  r_data_q,  w_data_d;
    logic [SELW-1:0]   r_chan_q,  w_chan_d;
    logic [SELW-1:0]   r_ptr_q,   w_ptr_d;

    logic              w_can_accept;
    logic              w_grant_vld;
    logic [SELW-1:0]   w_grant_idx;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_sel_data;
    int                w_off;
    int                w_best;

    assign out_valid    = (r_state_q == ST_FULL);
    assign out_data     = r_data_q;
    assign out_chan     = r_chan_q;
    assign w_can_accept = !out_valid || out_ready;

    // Grant: RR picks the valid channel at the smallest wrapped distance from ptr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_off       = 0;
        w_best      = NCH;
        for (int i = 0; i < NCH; i++) begin
            if (mode) begin
                if (in_valid[i]) begin
                    w_off = (i >= int'(r_ptr_q)) ? (i - int'(r_ptr_q))
                                                 : (i + NCH - int'(r_ptr_q));
                    if (w_off < w_best) begin
                        w_best      = w_off;
                        w_grant_vld = 1'b1;
                        w_grant_idx = SELW'(i);
                    end
                end
            end else if (in_valid[i] && (sel == SELW'(i))) begin
                w_grant_vld = 1'b1;
                w_grant_idx = SELW'(i);
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = !rst && w_can_accept && w_grant_vld && (w_grant_idx == SELW'(i));
            if (w_grant_idx == SELW'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = !rst && w_can_accept && w_grant_vld;

    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = r_data_q;
        w_chan_d  = r_chan_q;
        w_ptr_d   = r_ptr_q;
        if (w_xfer) begin
            w_state_d = ST_FULL;
            w_data_d  = w_sel_data;
            w_chan_d  = w_grant_idx;
            if (mode) begin
                w_ptr_d = (w_grant_idx == c_LAST_CH) ? '0 : w_grant_idx + 1'b1;
            end
        end else if ((r_state_q == ST_FULL) && out_ready) begin
            w_state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_EMPTY;
            r_data_q  <= '0;
            r_chan_q  <= '0;
            r_ptr_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_data_q  <= w_data_d;
            r_chan_q  <= w_chan_d;
            r_ptr_q   <= w_ptr_d;
        end
    end

`ifdef MUX_N_RR_STATS_EN
    logic [15:0] r_cnt_q, w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (out_valid && out_ready && (r_cnt_q != 16'hFFFF)) begin
            w_cnt_d = r_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign xfer_cnt = r_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_n_rr.sv
// ============================================================================
//  Module   : tb_mux_n_rr
//  Brief    : Directed scoreboard bench for mux_n_rr (NCH=4 and NCH=3 builds).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_n_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic [3:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;

`ifdef MUX_N_RR_STATS_EN
    logic [15:0] xfer_cnt;
    logic [15:0] xfer_cnt3;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_xfer = 0;
    logic [5:0]  sb[$];

    always #5 clk = ~clk;

    mux_n_rr #(.WIDTH(4), .NCH(4), .SELW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_N_RR_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    mux_n_rr #(.WIDTH(4), .NCH(3), .SELW(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (1'b0),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (1'b1)
`ifdef MUX_N_RR_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check ready/valid, pop a consumed word, push the word granted now.
    task automatic step(input string tag, input logic [3:0] exp_rdy,
                        input logic push, input logic [1:0] ch, input logic [3:0] d);
        logic [5:0] e;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
`ifdef MUX_N_RR_STATS_EN
        chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(exp_xfer));
`endif
        if ((sb.size() != 0) && out_ready) begin
            e = sb.pop_front();
            chk({tag, ".out_data"}, 32'(out_data), 32'(e[3:0]));
            chk({tag, ".out_chan"}, 32'(out_chan), 32'(e[5:4]));
            exp_xfer++;
        end
        if (push) sb.push_back({ch, d});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = {4'hD, 4'hC, 4'hB, 4'hA};
        in_valid  = 4'b1111;
        mode      = 1'b0;
        sel       = 2'd2;
        out_ready = 1'b1;
        in_data3  = {4'hC, 4'hB, 4'hA};
        in_valid3 = 3'b111;
        sel3      = 2'd3;

        // Reset held two cycles with every channel valid
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_data", 32'(out_data), 32'h0);
        chk("rst.out_chan", 32'(out_chan), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fixed select of channel 2
        repeat (3) step("fixed", 4'b0100, 1'b1, 2'd2, 4'hC);

        // Round-robin, all valid: every channel once per 4 cycles
        mode = 1'b1;
        repeat (2) begin
            step("rr", 4'b0001, 1'b1, 2'd0, 4'hA);
            step("rr", 4'b0010, 1'b1, 2'd1, 4'hB);
            step("rr", 4'b0100, 1'b1, 2'd2, 4'hC);
            step("rr", 4'b1000, 1'b1, 2'd3, 4'hD);
        end

        // Round-robin over channels 1 and 3 only
        in_valid = 4'b1010;
        repeat (2) begin
            step("rr_sparse", 4'b0010, 1'b1, 2'd1, 4'hB);
            step("rr_sparse", 4'b1000, 1'b1, 2'd3, 4'hD);
        end

        // Backpressure: grant B, stall 3 cycles, then release
        step("bp_grant", 4'b0010, 1'b1, 2'd1, 4'hB);
        out_ready = 1'b0;
        repeat (3) begin
            step("bp_hold", 4'b0000, 1'b0, 2'd0, 4'h0);
            chk("bp_hold.data", 32'(out_data), 32'hB);
            chk("bp_hold.chan", 32'(out_chan), 32'h1);
        end
        out_ready = 1'b1;
        step("bp_release", 4'b1000, 1'b1, 2'd3, 4'hD);

        // No valid inputs: pending word drains then out_valid drops
        in_valid = 4'b0000;
        step("drain", 4'b0000, 1'b0, 2'd0, 4'h0);
        step("idle", 4'b0000, 1'b0, 2'd0, 4'h0);

        // Reset while a word is held discards it
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0001;
        step("pre_rst", 4'b0001, 1'b1, 2'd0, 4'hA);
        out_ready = 1'b0;
        rst       = 1'b1;
        in_valid  = 4'b0000;
        step("mid_rst", 4'b0000, 1'b0, 2'd0, 4'h0);
        sb.delete();
        exp_xfer  = 0;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst.out_valid", 32'(out_valid), 32'h0);
        chk("post_rst.out_data", 32'(out_data), 32'h0);
        chk("post_rst.out_chan", 32'(out_chan), 32'h0);
        @(posedge clk); #1;

        // NCH=3 with sel=3: never a grant
        repeat (2) begin
            @(negedge clk);
            chk("badsel.in_ready", 32'(in_ready3), 32'h0);
            chk("badsel.out_valid", 32'(out_valid3), 32'h0);
            @(posedge clk); #1;
        end
        sel3 = 2'd1;
        @(negedge clk);
        chk("sel1.in_ready", 32'(in_ready3), 32'h2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sel1.out_valid", 32'(out_valid3), 32'h1);
        chk("sel1.out_data", 32'(out_data3), 32'hB);
        chk("sel1.out_chan", 32'(out_chan3), 32'h1);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
